// File: rtl/if_stage_if.sv
// Bundle of the IF stage: instruction-memory handshake, EX redirect and IF/ID outputs.
// The master side is the fetch stage; the slave side is memory plus the pipeline behind it.
interface if_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   modport master (
      input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
      output imem_req, imem_addr, if_valid, if_pc, if_instr
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_ack, imem_rdata,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, output register O plus a one-entry
// skid register S so that a stall never loses or duplicates a fetched instruction.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic      clk,
   input  logic      rst_n,
   if_stage_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_FETCH   = 2'b01,
      ST_DISCARD = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_req_addr;
   logic        r_if_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_instr;
   logic        r_s_valid;
   logic [31:0] r_s_pc;
   logic [31:0] r_s_instr;

   logic        w_req;
   logic        w_accept;
   logic        w_consume;
   logic [31:0] w_redirect_pc;

   assign w_req         = (r_state == ST_FETCH) & ~r_s_valid;
   assign w_accept      = w_req & bus.imem_ack & ~bus.redirect;
   assign w_consume     = r_if_valid & ~bus.stall & ~bus.redirect;
   assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

   assign bus.imem_req  = w_req;
   // Outside FETCH the address of the abandoned-but-outstanding request stays visible.
   assign bus.imem_addr = (r_state == ST_FETCH) ? r_fetch_pc : r_req_addr;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_pc     = r_if_pc;
   assign bus.if_instr  = r_if_instr;

   // Next-state logic for the fetch controller.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.redirect && w_req && !bus.imem_ack) begin
               w_state_nxt = ST_DISCARD;
            end else begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            if (bus.imem_ack) begin
               w_state_nxt = ST_FETCH;
            end else begin
               w_state_nxt = ST_DISCARD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fetch address and the address of the request currently on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else begin
         if (bus.redirect) begin
            r_fetch_pc <= w_redirect_pc;
         end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end else begin
            r_fetch_pc <= r_fetch_pc;
         end
         if (w_req) begin
            r_req_addr <= r_fetch_pc;
         end else begin
            r_req_addr <= r_req_addr;
         end
      end
   end

   // Output register O and skid register S.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_valid <= 1'b0;
         r_if_pc    <= 32'h0000_0000;
         r_if_instr <= 32'h0000_0013;
         r_s_valid  <= 1'b0;
         r_s_pc     <= 32'h0000_0000;
         r_s_instr  <= 32'h0000_0000;
      end else if (bus.redirect) begin
         r_if_valid <= 1'b0;
         r_s_valid  <= 1'b0;
      end else if (w_accept) begin
         // S is always empty here because a full S blocks the request.
         if (!r_if_valid || w_consume) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_fetch_pc;
            r_if_instr <= bus.imem_rdata;
         end else begin
            r_s_valid  <= 1'b1;
            r_s_pc     <= r_fetch_pc;
            r_s_instr  <= bus.imem_rdata;
         end
      end else if (w_consume) begin
         if (r_s_valid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_s_pc;
            r_if_instr <= r_s_instr;
            r_s_valid  <= 1'b0;
         end else begin
            r_if_valid <= 1'b0;
         end
      end else begin
         r_if_valid <= r_if_valid;
         r_s_valid  <= r_s_valid;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a cycle table for the directed corner cases, a reset-mid-request
// sequence, and a randomized phase checked against a scoreboard queue.
module tb_if_stage;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   if_stage_if bus ();
   if_stage_if bus2 ();

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   assign bus.imem_rdata   = mem_word(bus.imem_addr);
   assign bus2.imem_rdata  = mem_word(bus2.imem_addr);
   assign bus2.imem_ack    = 1'b1;
   assign bus2.stall       = 1'b0;
   assign bus2.redirect    = 1'b0;
   assign bus2.redirect_pc = 32'h0000_0000;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, want %08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        ack;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                               input logic a, input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep);
      vec_t v;
      v.stall = s; v.redirect = r; v.rpc = rpc; v.ack = a;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
      return v;
   endfunction

   vec_t        tbl [17];
   ent_t        q [$];
   logic [31:0] exp_fetch;
   logic        disc;
   logic        exp_req;
   logic        st, rd, ak;
   logic [31:0] rpc;

   initial begin
      // Row k: expected outputs after k edges since reset release, then inputs for the next edge.
      tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
      tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
      tbl[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0);
      tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4);
      tbl[4]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8);
      tbl[5]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8);
      tbl[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8);
      tbl[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8);
      tbl[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC);
      tbl[9]  = mk(1'b0, 1'b1, 32'h203, 1'b1, 1'b1, 32'h14,  1'b1, 32'h10);
      tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b1, 32'h200);
      tbl[12] = mk(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0);
      tbl[13] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
      tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
      tbl[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
      tbl[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100);

      rst_n           = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.imem_ack    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      check("rst_if_pc",    bus.if_pc,    32'h0);
      check("rst_if_instr", bus.if_instr, 32'h0000_0013);

      for (int k = 0; k < 17; k++) begin
         check($sformatf("tbl%0d_req", k),   {31'h0, bus.imem_req}, {31'h0, tbl[k].e_req});
         if (tbl[k].e_req)
            check($sformatf("tbl%0d_addr", k), bus.imem_addr, tbl[k].e_addr);
         check($sformatf("tbl%0d_valid", k), {31'h0, bus.if_valid}, {31'h0, tbl[k].e_valid});
         if (tbl[k].e_valid) begin
            check($sformatf("tbl%0d_pc", k),    bus.if_pc,    tbl[k].e_pc);
            check($sformatf("tbl%0d_instr", k), bus.if_instr, mem_word(tbl[k].e_pc));
         end
         if (k >= 2 && k <= 5)
            check($sformatf("wrap%0d_pc", k), bus2.if_pc, 32'hFFFF_FFF8 + 32'd4 * (k - 2));
         bus.stall       = tbl[k].stall;
         bus.redirect    = tbl[k].redirect;
         bus.redirect_pc = tbl[k].rpc;
         bus.imem_ack    = tbl[k].ack;
         @(posedge clk);
         #1;
      end

      // Reset pulse with a request outstanding, then an ack during the IDLE cycle.
      bus.stall    = 1'b1;
      bus.redirect = 1'b0;
      bus.imem_ack = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_req", {31'h0, bus.imem_req}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'h0, bus.if_valid}, 32'h0);
      check("arst_pc",    bus.if_pc,    32'h0);
      check("arst_instr", bus.if_instr, 32'h0000_0013);
      check("arst_req",   {31'h0, bus.imem_req}, 32'h0);
      bus.imem_ack = 1'b1;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      bus.stall = 1'b0;
      check("idle_req", {31'h0, bus.imem_req}, 32'h0);
      @(posedge clk);
      #1;
      check("post_idle_req",   {31'h0, bus.imem_req}, 32'h1);
      check("post_idle_addr",  bus.imem_addr, 32'h0);
      check("post_idle_valid", {31'h0, bus.if_valid}, 32'h0);
      @(posedge clk);
      #1;
      check("restart_valid", {31'h0, bus.if_valid}, 32'h1);
      check("restart_pc",    bus.if_pc,    32'h0);
      check("restart_instr", bus.if_instr, mem_word(32'h0));

      // Randomized phase: the queue holds every accepted, not yet consumed instruction.
      q.delete();
      q.push_back('{32'h0, mem_word(32'h0)});
      exp_fetch = 32'h4;
      disc      = 1'b0;
      for (int c = 0; c < 400; c++) begin
         exp_req = !disc && (q.size() < 2);
         check("rnd_req", {31'h0, bus.imem_req}, {31'h0, exp_req});
         if (exp_req)
            check("rnd_addr", bus.imem_addr, exp_fetch);
         check("rnd_valid", {31'h0, bus.if_valid}, {31'h0, (q.size() != 0)});
         if (q.size() != 0) begin
            check("rnd_pc",    bus.if_pc,    q[0].pc);
            check("rnd_instr", bus.if_instr, q[0].instr);
         end
         st  = ($urandom_range(0, 2) == 0);
         rd  = !disc && ($urandom_range(0, 19) == 0);
         rpc = $urandom;
         ak  = (bus.imem_req || disc) && ($urandom_range(0, 1) == 1);
         bus.stall       = st;
         bus.redirect    = rd;
         bus.redirect_pc = rpc;
         bus.imem_ack    = ak;
         if (rd) begin
            if (exp_req && !ak) disc = 1'b1;
            q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
         end else begin
            if (disc && ak) disc = 1'b0;
            if (q.size() != 0 && !st) void'(q.pop_front());
            if (exp_req && ak) begin
               q.push_back('{exp_fetch, mem_word(exp_fetch)});
               exp_fetch = exp_fetch + 32'd4;
            end
         end
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
